yapp_tx: RTL and testbench

- Synthesizable YAPP packet transmitter: the sending end of the router's YAPP input port.
- Drives in_data, in_data_vld and honours in_suspend.
- Accepts a packet command plus its payload stream from an on-chip source, buffers the full payload, then serializes header, payload and parity contiguously.
- Used as a hardware traffic source in the accelerated testbench, on the same clock/reset as the router.

---
 rtl/yapp_tx_pkg.sv | 20 ++
 rtl/yapp_tx_buf.sv | 26 ++
 rtl/yapp_tx.sv | 178 +++++++++++++++++
 tb/tb_yapp_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yapp_tx_pkg.sv
// rtl/yapp_tx_pkg.sv - shared types, constants and header helper for the YAPP transmitter
package yapp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HDR  = 3'd2,
        ST_PLD  = 3'd3,
        ST_PAR  = 3'd4,
        ST_GAP  = 3'd5
    } yapp_state_e;

    localparam int         YAPP_MAX_LEN = 63;
    localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

    function automatic logic [7:0] yapp_header(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/yapp_tx_buf.sv
// rtl/yapp_tx_buf.sv - payload buffer, one synchronous write port and one asynchronous read port
module yapp_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    // Store one payload byte per accepted load cycle; contents need no reset.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Async read so buffer[0] is already on the bus in the first payload cycle.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/yapp_tx.sv
// rtl/yapp_tx.sv - YAPP packet transmitter: buffers a payload, then sends header, payload and parity
module yapp_tx
    import yapp_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_LEN    = YAPP_MAX_LEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_parity,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    output logic [7:0] in_data,
    output logic       in_data_vld,
    input  logic       in_suspend,
    output logic       busy,
    output logic       pkt_done
);

    // The IDLE cycle in which the next command is accepted is itself the last
    // idle cycle on the link, so GAP only has to cover GAP_CYCLES-1 cycles.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 2) : 4'd0;
    localparam bit         USE_GAP  = (GAP_CYCLES > 1);

    yapp_state_e r_state;
    yapp_state_e w_next;

    logic [1:0] r_addr;
    logic [5:0] r_len;
    logic       r_bad;
    logic [5:0] r_cnt;
    logic [5:0] r_rd_ptr;
    logic [7:0] r_parity;
    logic [3:0] r_gap_cnt;
    logic       r_pkt_done;

    logic       w_wr_en;
    logic [7:0] w_rd_data;
    logic [7:0] w_hdr;
    logic       w_last_load;
    logic       w_last_rd;

    assign w_hdr       = yapp_header(r_len, r_addr);
    assign w_last_load = (r_cnt == (r_len - 6'd1));
    assign w_last_rd   = (r_rd_ptr == (r_len - 6'd1));
    assign busy        = (r_state != ST_IDLE);
    assign pkt_done    = r_pkt_done;

    yapp_tx_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (6)
    ) u_buf (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_cnt),
        .i_wr_data (pl_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and link/handshake outputs; link outputs freeze while suspended
    // because the state and pointers only advance on a real transfer.
    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        pl_ready    = 1'b0;
        in_data     = 8'h00;
        in_data_vld = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    w_next = (cmd_len == 6'd0) ? ST_HDR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    w_wr_en = 1'b1;
                    if (w_last_load) begin
                        w_next = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                in_data     = w_hdr;
                in_data_vld = 1'b1;
                if (!in_suspend) begin
                    w_next = (r_len == 6'd0) ? ST_PAR : ST_PLD;
                end
            end
            ST_PLD: begin
                in_data     = w_rd_data;
                in_data_vld = 1'b1;
                if (!in_suspend && w_last_rd) begin
                    w_next = ST_PAR;
                end
            end
            ST_PAR: begin
                in_data     = r_bad ? ~r_parity : r_parity;
                in_data_vld = 1'b1;
                if (!in_suspend) begin
                    w_next = USE_GAP ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, load counter, running parity, read pointer, gap counter and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= 2'd0;
            r_len      <= 6'd0;
            r_bad      <= 1'b0;
            r_cnt      <= 6'd0;
            r_rd_ptr   <= 6'd0;
            r_parity   <= 8'h00;
            r_gap_cnt  <= 4'd0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= (r_state == ST_PAR) && !in_suspend;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr   <= cmd_addr;
                        r_len    <= cmd_len;
                        r_bad    <= cmd_bad_parity;
                        r_cnt    <= 6'd0;
                        r_parity <= yapp_header(cmd_len, cmd_addr);
                    end
                end
                ST_LOAD: begin
                    if (pl_valid) begin
                        r_parity <= r_parity ^ pl_data;
                        r_cnt    <= r_cnt + 6'd1;
                    end
                end
                ST_HDR: begin
                    r_rd_ptr <= 6'd0;
                end
                ST_PLD: begin
                    if (!in_suspend) begin
                        r_rd_ptr <= r_rd_ptr + 6'd1;
                    end
                end
                ST_PAR: begin
                    r_gap_cnt <= 4'd0;
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yapp_tx.sv
// tb/tb_yapp_tx.sv - directed self-checking bench for yapp_tx
module tb_yapp_tx;
    import yapp_tx_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = 2'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       cmd_bad_parity = 1'b0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] pl_data = 8'h00;
    logic [7:0] in_data;
    logic       in_data_vld;
    logic       in_suspend = 1'b0;
    logic       busy;
    logic       pkt_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_q[$];
    logic [7:0] eq[$];
    logic [7:0] pq[$];
    int vld_cycles = 0;
    int done_cnt = 0;
    int plr_cycles = 0;
    int zero_run = 0;
    int last_gap = 0;

    always #5 clock = ~clock;

    yapp_tx #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_bad_parity (cmd_bad_parity),
        .pl_valid       (pl_valid),
        .pl_ready       (pl_ready),
        .pl_data        (pl_data),
        .in_data        (in_data),
        .in_data_vld    (in_data_vld),
        .in_suspend     (in_suspend),
        .busy           (busy),
        .pkt_done       (pkt_done)
    );

    // Link monitor: records transferred bytes, valid cycles, idle-run lengths and pulses.
    always @(negedge clock) begin
        if (in_data_vld && !in_suspend) mon_q.push_back(in_data);
        if (in_data_vld) begin
            if (zero_run > 0) last_gap <= zero_run;
            zero_run   <= 0;
            vld_cycles <= vld_cycles + 1;
        end else begin
            zero_run <= zero_run + 1;
        end
        if (pkt_done) done_cnt <= done_cnt + 1;
        if (pl_ready) plr_cycles <= plr_cycles + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input int base);
        logic [31:0] obs;
        chk({tag, "_count"}, 32'(mon_q.size() - base), 32'(eq.size()));
        foreach (eq[i]) begin
            obs = (base + i < mon_q.size()) ? 32'(mon_q[base + i]) : 32'hDEAD;
            chk(tag, obs, 32'(eq[i]));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic b);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            step(1);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid      = 1'b1;
        cmd_addr       = a;
        cmd_len        = l;
        cmd_bad_parity = b;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            pl_valid = 1'b1;
            pl_data  = pq[i];
            step(1);
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!pkt_done && n < 300) begin
            step(1);
            n++;
        end
        chk({tag, "_pkt_done_seen"}, 32'(pkt_done), 1);
    endtask

    initial begin
        int base;
        int v0;
        int d0;
        int p0;
        logic [7:0] par;
        logic [7:0] tmp;

        // Reset state, with reset still high
        step(1);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_vld", 32'(in_data_vld), 0);
        chk("rst_in_data", 32'(in_data), 0);
        chk("rst_pl_ready", 32'(pl_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt_done", 32'(pkt_done), 0);
        reset = 1'b0;
        step(1);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);

        // len=3 addr=1
        base = mon_q.size(); v0 = vld_cycles; d0 = done_cnt;
        pq = '{8'h11, 8'h22, 8'h33};
        send_cmd(2'd1, 6'd3, 1'b0);
        feed(3);
        chk("t1_hdr_latency", 32'({in_data_vld, in_data}), 32'({1'b1, 8'h0D}));
        wait_done("t1");
        step(2);
        eq = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33};
        chk_stream("t1_bytes", base);
        chk("t1_vld_cycles", 32'(vld_cycles - v0), 5);
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);

        // len=0 addr=2, stray pl_valid held high throughout
        base = mon_q.size(); v0 = vld_cycles; p0 = plr_cycles;
        pl_valid = 1'b1;
        pl_data  = 8'hFF;
        send_cmd(2'd2, 6'd0, 1'b0);
        wait_done("t2");
        pl_valid = 1'b0;
        step(2);
        eq = '{8'h02, 8'h02};
        chk_stream("t2_bytes", base);
        chk("t2_vld_cycles", 32'(vld_cycles - v0), 2);
        chk("t2_pl_ready_cycles", 32'(plr_cycles - p0), 0);

        // len=0 to the address the router drops
        base = mon_q.size();
        send_cmd(ADDR_ILLEGAL, 6'd0, 1'b0);
        wait_done("t3");
        step(2);
        eq = '{8'h03, 8'h03};
        chk_stream("t3_bytes", base);

        // len=4, suspend for 3 cycles on the second payload byte
        base = mon_q.size(); v0 = vld_cycles;
        pq = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_cmd(2'd2, 6'd4, 1'b0);
        feed(4);
        chk("t4_hdr_latency", 32'({in_data_vld, in_data}), 32'({1'b1, 8'h12}));
        step(2);
        chk("t4_second_byte", 32'(in_data), 32'h20);
        in_suspend = 1'b1;
        repeat (3) begin
            step(1);
            chk("t4_frozen", 32'({in_data_vld, in_data}), 32'({1'b1, 8'h20}));
        end
        in_suspend = 1'b0;
        wait_done("t4");
        step(2);
        eq = '{8'h12, 8'h10, 8'h20, 8'h30, 8'h40, 8'h12 ^ 8'h10 ^ 8'h20 ^ 8'h30 ^ 8'h40};
        chk_stream("t4_bytes", base);
        chk("t4_vld_cycles", 32'(vld_cycles - v0), 9);

        // bad parity, len=1 addr=0, suspend in header, stray command while busy
        base = mon_q.size();
        pq = '{8'hA5};
        send_cmd(2'd0, 6'd1, 1'b1);
        feed(1);
        in_suspend     = 1'b1;
        cmd_valid      = 1'b1;
        cmd_addr       = 2'd2;
        cmd_len        = 6'd5;
        cmd_bad_parity = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        chk("t5_hdr_held", 32'({in_data_vld, in_data}), 32'({1'b1, 8'h04}));
        step(1);
        chk("t5_hdr_held2", 32'({in_data_vld, in_data}), 32'({1'b1, 8'h04}));
        in_suspend = 1'b0;
        wait_done("t5");
        step(2);
        tmp = 8'h04 ^ 8'hA5;
        eq = '{8'h04, 8'hA5, ~tmp};
        chk_stream("t5_bytes", base);
        chk("t5_idle_after", 32'({busy, cmd_ready}), 32'({1'b0, 1'b1}));

        // back-to-back packets across a GAP_CYCLES=2 gap
        base = mon_q.size();
        pq = '{8'h5A};
        send_cmd(2'd1, 6'd1, 1'b0);
        feed(1);
        wait_done("t6a");
        chk("t6_gap_cmd_ready", 32'(cmd_ready), 0);
        chk("t6_gap_busy", 32'(busy), 1);
        step(1);
        chk("t6_ready_after_gap", 32'(cmd_ready), 1);
        send_cmd(2'd0, 6'd0, 1'b0);
        wait_done("t6b");
        step(2);
        chk("t6_gap_len", 32'(last_gap), 2);
        eq = '{8'h05, 8'h5A, 8'h05 ^ 8'h5A, 8'h00, 8'h00};
        chk_stream("t6_bytes", base);

        // full-length packet
        base = mon_q.size();
        pq.delete();
        for (int i = 0; i < 63; i++) pq.push_back(8'(i) ^ 8'h5A);
        par = 8'hFD;
        eq = '{8'hFD};
        for (int i = 0; i < 63; i++) begin
            par = par ^ pq[i];
            eq.push_back(pq[i]);
        end
        eq.push_back(par);
        send_cmd(2'd1, 6'd63, 1'b0);
        feed(63);
        chk("t7_hdr_latency", 32'({in_data_vld, in_data}), 32'({1'b1, 8'hFD}));
        wait_done("t7");
        step(2);
        chk_stream("t7_bytes", base);

        // reset in the middle of a len=63 load
        d0 = done_cnt; v0 = vld_cycles; base = mon_q.size();
        send_cmd(2'd2, 6'd63, 1'b0);
        feed(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t8_vld_after_reset", 32'(in_data_vld), 0);
        chk("t8_busy_after_reset", 32'(busy), 0);
        step(5);
        chk("t8_no_done", 32'(done_cnt - d0), 0);
        chk("t8_no_bytes", 32'(mon_q.size() - base), 0);
        chk("t8_no_vld", 32'(vld_cycles - v0), 0);

        // next packet after the abort
        base = mon_q.size();
        pq = '{8'h3C};
        send_cmd(2'd3, 6'd1, 1'b0);
        feed(1);
        wait_done("t9");
        step(2);
        eq = '{8'h07, 8'h3C, 8'h07 ^ 8'h3C};
        chk_stream("t9_bytes", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
